// File: rtl/drain_sched.sv
// rtl/drain_sched.sv - round-robin drain of four FIFOs into one sink with per-channel delivery counters

module drain_sched #(
    parameter int DATA_SIZE = 12,
    parameter int CNT_SIZE  = 5
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [3:0]           empty,
    input  logic [DATA_SIZE-1:0] data_in0,
    input  logic [DATA_SIZE-1:0] data_in1,
    input  logic [DATA_SIZE-1:0] data_in2,
    input  logic [DATA_SIZE-1:0] data_in3,
    input  logic                 sink_ready,
    output logic                 pop0,
    output logic                 pop1,
    output logic                 pop2,
    output logic                 pop3,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    input  logic                 req,
    input  logic [2:0]           idx,
    output logic [CNT_SIZE-1:0]  data_out_cont,
    output logic                 valid_cont
);

    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_INIT   = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

    logic [1:0]          state;
    logic [1:0]          next_state;
    logic [1:0]          ptr;
    logic [3:0]          pop_q;
    logic [3:0]          pop_next;
    logic [1:0]          pop_ch;
    logic                pop_found;
    logic [1:0]          cand;
    logic [3:0]          pop_d;
    logic [1:0]          d_ch;
    logic [DATA_SIZE-1:0] d_word;
    logic [1:0]          src;
    logic [CNT_SIZE-1:0] cnt [4];
    logic [CNT_SIZE-1:0] cnt_sum;

    assign pop0 = pop_q[0];
    assign pop1 = pop_q[1];
    assign pop2 = pop_q[2];
    assign pop3 = pop_q[3];

    // Next-state decision; init overrides everything else
    always_comb begin
        next_state = state;
        if (init) begin
            next_state = ST_INIT;
        end else begin
            case (state)
                ST_RESET:  next_state = ST_IDLE;
                ST_INIT:   next_state = ST_IDLE;
                ST_IDLE:   next_state = (sink_ready && !(&empty)) ? ST_ACTIVE : ST_IDLE;
                ST_ACTIVE: next_state = (!sink_ready || (&empty)) ? ST_IDLE : ST_ACTIVE;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    // Round-robin pick for the next cycle's pop. The channel popped this
    // cycle is skipped because its empty flag still counts the word being
    // removed, so a second back-to-back pop could underflow the FIFO.
    always_comb begin
        pop_next  = 4'b0000;
        pop_found = 1'b0;
        pop_ch    = ptr;
        cand      = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!pop_found && !empty[cand] && !pop_q[cand]) begin
                pop_found = 1'b1;
                pop_ch    = cand;
            end
        end
        if (next_state == ST_ACTIVE && pop_found) begin
            pop_next[pop_ch] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state <= ST_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Registered pop strobes and round-robin pointer
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            pop_q <= 4'b0000;
            ptr   <= 2'd0;
        end else begin
            pop_q <= pop_next;
            if (|pop_next) begin
                ptr <= pop_ch + 2'd1;
            end
        end
    end

    // Channel whose read data is on data_inN this cycle
    always_comb begin
        d_ch = 2'd0;
        if (pop_d[1]) d_ch = 2'd1;
        if (pop_d[2]) d_ch = 2'd2;
        if (pop_d[3]) d_ch = 2'd3;
    end

    // Read-data select for the channel popped last cycle
    always_comb begin
        case (d_ch)
            2'd0:    d_word = data_in0;
            2'd1:    d_word = data_in1;
            2'd2:    d_word = data_in2;
            default: d_word = data_in3;
        endcase
    end

    // Delivery pipeline: runs independently of sink_ready so an issued pop is never dropped
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            pop_d     <= 4'b0000;
            data_out  <= '0;
            valid_out <= 1'b0;
            src       <= 2'd0;
        end else begin
            pop_d     <= pop_q;
            valid_out <= |pop_d;
            if (|pop_d) begin
                data_out <= d_word;
                src      <= d_ch;
            end
        end
    end

    // Per-channel delivery counters, cleared in reset and held at zero in INIT
    always_ff @(posedge clk) begin
        if (!reset_L || state == ST_INIT) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else if (valid_out) begin
            cnt[src] <= cnt[src] + 1'b1;
        end
    end

    // Modular sum of all counters for the idx=4 read
    always_comb begin
        cnt_sum = cnt[0] + cnt[1] + cnt[2] + cnt[3];
    end

    // Counter read port; samples pre-increment values when a delivery lands the same cycle
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            data_out_cont <= '0;
            valid_cont    <= 1'b0;
        end else if (req && idx < 3'd4) begin
            data_out_cont <= cnt[idx[1:0]];
            valid_cont    <= 1'b1;
        end else if (req && idx == 3'd4) begin
            data_out_cont <= cnt_sum;
            valid_cont    <= 1'b1;
        end else begin
            data_out_cont <= '0;
            valid_cont    <= 1'b0;
        end
    end

endmodule
